// File: rtl/dev_timer_pkg.sv
// Shared definitions for dev_timer: FSM encoding, register offsets, CTRL layout, MODE codes.
package dev_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESET   = 2'd1;
  localparam logic [1:0] ADDR_COUNT    = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Field order mirrors the CTRL bit positions above (im=3, mode=2:1, en=0).
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Codes 10/11 fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

  function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
    ctrl_t c;
    c.en   = w[CTRL_EN_BIT];
    c.mode = w[CTRL_MODE_LSB +: 2];
    c.im   = w[CTRL_IM_BIT];
    return c;
  endfunction

endpackage

// File: rtl/dev_timer_prescale.sv
// Prescaler for dev_timer: one-cycle tick every prescale+1 running cycles.
// Only built when DEV_TIMER_PRESCALE_EN is defined.
`ifdef DEV_TIMER_PRESCALE_EN
module dev_timer_prescale (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       run,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] pc;

  // >= keeps ticking sane if PRESCALE is lowered below the running count.
  assign tick = run && (pc >= prescale);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   pc <= '0;
    else if (clr) pc <= '0;
    else if (run) pc <= tick ? 8'd0 : pc + 8'd1;
  end

endmodule
`endif

// File: rtl/dev_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and masked irq.
// Optional PRESCALE register and prescaler enabled by DEV_TIMER_PRESCALE_EN.
module dev_timer
  import dev_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [7:0]  prescale;
  logic        pend;

  state_e      state, state_nxt;

  logic        ctrl_wr, preset_wr;
  logic        en_eff;
  logic        tick;
  logic        do_load, do_dec, do_zero, do_int;

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign preset_wr = we && (addr == ADDR_PRESET);

  // The FSM sees an in-flight CTRL write so enable/disable act on the write edge.
  assign en_eff = ctrl_wr ? wd[CTRL_EN_BIT] : ctrl.en;

`ifdef DEV_TIMER_PRESCALE_EN
  logic prescale_wr;
  assign prescale_wr = we && (addr == ADDR_PRESCALE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           prescale <= '0;
    else if (prescale_wr) prescale <= wd[7:0];
  end

  dev_timer_prescale u_prescale (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == ST_LOAD),
    .run      (state == ST_CNT),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign prescale = 8'd0;
  assign tick     = 1'b1;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (en_eff) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_CNT;
      ST_CNT: begin
        if (!en_eff)                 state_nxt = ST_IDLE;
        else if (tick && count <= 1) state_nxt = ST_INT;
      end
      ST_INT:  state_nxt = is_reload(ctrl.mode) ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: datapath strobes
  always_comb begin
    do_load = (state == ST_LOAD);
    do_int  = (state == ST_INT);
    do_dec  = 1'b0;
    do_zero = 1'b0;
    if (state == ST_CNT && en_eff && tick) begin
      if (count > 1) do_dec  = 1'b1;
      else           do_zero = 1'b1;
    end
  end

  // CPU writes win over the end-of-count EN clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 ctrl    <= '0;
    else if (ctrl_wr)                           ctrl    <= ctrl_from_word(wd);
    else if (do_int && !is_reload(ctrl.mode))   ctrl.en <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         preset <= '0;
    else if (preset_wr) preset <= wd;
  end

  // COUNT has no CPU write path; PRESET only reaches it through LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       count <= '0;
    else if (do_load) count <= preset;
    else if (do_dec)  count <= count - 32'd1;
    else if (do_zero) count <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       pend <= 1'b0;
    else if (ctrl_wr) pend <= 1'b0;
    else if (do_int)  pend <= 1'b1;
  end

  assign irq = pend & ctrl.im;

  always_comb begin
    rd = '0;
    unique case (addr)
      ADDR_CTRL:     rd = {28'd0, ctrl};
      ADDR_PRESET:   rd = preset;
      ADDR_COUNT:    rd = count;
      ADDR_PRESCALE: rd = {24'd0, prescale};
      default:       rd = '0;
    endcase
  end

endmodule

// File: tb/tb_dev_timer.sv
// Self-checking bench for dev_timer: directed steps with randomized parameters
// checked against an arithmetic timeline model of the timer.
module tb_dev_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  int S = 1;  // cycles per COUNT decrement

  localparam logic [1:0] A_CTRL = 2'd0, A_PRESET = 2'd1, A_COUNT = 2'd2, A_PS = 2'd3;

  dev_timer dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdr(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  // One-shot timeline: after the enabling write edge e0, LOAD at e0, COUNT=n at e1,
  // each value held S cycles, COUNT=0 (INT) at e(1+m*S), pend from e(2+m*S).
  task automatic run_oneshot(input int n, input bit im, input logic [1:0] mode,
                             input int pw, input logic [31:0] pv);
    int m, last, step;
    logic [31:0] v, ec;
    bit ei;
    wr(A_PRESET, 32'(n));
    wr(A_CTRL, {28'd0, im, mode, 1'b1});
    m = (n == 0) ? 1 : n;
    last = m * S + 4;
    for (int j = 1; j <= last; j++) begin
      if (j == pw) begin we = 1'b1; addr = A_PRESET; wd = pv; end
      tick();
      we = 1'b0;
      step = (j - 1) / S;
      ec = (j <= m * S + 1 && step < n) ? 32'(n - step) : 32'd0;
      ei = im && (j >= m * S + 2);
      rdr(A_COUNT, v);
      chk("oneshot_count", v, ec);
      chk("oneshot_irq", {31'd0, irq}, {31'd0, ei});
    end
    rdr(A_CTRL, v);
    chk("oneshot_ctrl_en_cleared", v, {28'd0, im, mode, 1'b0});
  endtask

  // Auto-reload: period p=m+2 edges; pend set at multiples of p unless a CTRL
  // write lands on that edge. Writes at p+1 (plain clear) and 3p (collides with set).
  task automatic run_reload(input int n, input bit im);
    int m, p, ph;
    bit mp, wrn;
    logic [31:0] v, ec, cw;
    cw = {28'd0, im, 2'b01, 1'b1};
    wr(A_PRESET, 32'(n));
    wr(A_CTRL, cw);
    m = (n == 0) ? 1 : n;
    p = m + 2;
    mp = 1'b0;
    for (int j = 1; j <= 3 * p + 2; j++) begin
      wrn = (j == p + 1) || (j == 3 * p);
      if (wrn) begin we = 1'b1; addr = A_CTRL; wd = cw; end
      tick();
      we = 1'b0;
      if (wrn)             mp = 1'b0;
      else if (j % p == 0) mp = 1'b1;
      ph = j % p;
      ec = (ph >= 1 && ph <= m && (ph - 1) < n) ? 32'(n - (ph - 1)) : 32'd0;
      rdr(A_COUNT, v);
      chk("reload_count", v, ec);
      chk("reload_irq", {31'd0, irq}, {31'd0, mp & im});
    end
    wr(A_CTRL, 32'd0);
    repeat (4) tick();
    chk("reload_stop_irq", {31'd0, irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int n, r, ps;
    bit im, found;
    logic [1:0] mode;

    // reset state
    reset = 1'b0;
    repeat (2) tick();
    for (int a = 0; a < 4; a++) begin
      rdr(2'(a), v);
      chk("reset_reg", v, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    tick();

    // CTRL upper bits read 0; EN=0 keeps timer idle
    wr(A_CTRL, 32'hFFFF_FFF6);
    rdr(A_CTRL, v);
    chk("ctrl_upper_zero", v, 32'h6);
    wr(A_CTRL, 32'd0);

`ifdef DEV_TIMER_PRESCALE_EN
    wr(A_PS, 32'hFFFF_FF02);
    rdr(A_PS, v);
    chk("prescale_read", v, 32'h2);
    S = 3;
    run_oneshot(2, 1'b1, 2'b00, 0, 32'd0);
`else
    wr(A_PS, 32'h0000_00A5);
    rdr(A_PS, v);
    chk("prescale_absent", v, 32'd0);
    S = 1;
`endif

    // canonical one-shot and boundaries
    run_oneshot(5, 1'b1, 2'b00, 0, 32'd0);
    run_oneshot(0, 1'b1, 2'b00, 0, 32'd0);
    run_oneshot(1, 1'b1, 2'b11, 0, 32'd0);

    // masked irq, then a CTRL write must have cleared the hidden pend
    run_oneshot(2, 1'b0, 2'b00, 0, 32'd0);
    wr(A_CTRL, 32'h8);
    repeat (3) begin
      tick();
      chk("im_after_clear_irq", {31'd0, irq}, 32'd0);
    end

    // randomized one-shot runs
    for (int it = 0; it < 6; it++) begin
`ifdef DEV_TIMER_PRESCALE_EN
      ps = $urandom_range(0, 2);
      wr(A_PS, 32'(ps));
      S = ps + 1;
`else
      ps = 0;
      S = 1;
`endif
      n = $urandom_range(0, 12);
      im = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 2);
      mode = (r == 0) ? 2'b00 : 2'(r + 1);
      run_oneshot(n, im, mode, 0, 32'd0);
    end

`ifdef DEV_TIMER_PRESCALE_EN
    wr(A_PS, 32'd0);
`endif
    S = 1;

    // PRESET write mid-count leaves COUNT alone, applies at next LOAD
    run_oneshot(10, 1'b1, 2'b00, 3, 32'd9);
    rdr(A_PRESET, v);
    chk("preset_mid_write", v, 32'd9);
    wr(A_CTRL, 32'h1);
    tick();
    rdr(A_COUNT, v);
    chk("preset_next_load", v, 32'd9);
    wr(A_CTRL, 32'd0);

    // auto-reload
    run_reload(3, 1'b1);
    run_reload($urandom_range(0, 6), 1'b1);
    run_reload(2, 1'b0);

    // mid-count disable at COUNT=7
    wr(A_PRESET, 32'd20);
    wr(A_CTRL, 32'h1);
    found = 1'b0;
    v = 32'd0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      rdr(A_COUNT, v);
      if (v == 32'd7) found = 1'b1;
    end
    chk("reach_count7", v, 32'd7);
    we = 1'b1; addr = A_CTRL; wd = 32'd0;
    tick();
    we = 1'b0;
    repeat (10) begin
      tick();
      rdr(A_COUNT, v);
      chk("frozen_count", v, 32'd7);
    end
    wr(A_COUNT, 32'h99);
    rdr(A_COUNT, v);
    chk("count_read_only", v, 32'd7);

    // async reset mid-count at COUNT=4
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    found = 1'b0;
    v = 32'd0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      rdr(A_COUNT, v);
      if (v == 32'd4) found = 1'b1;
    end
    chk("reach_count4", v, 32'd4);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rdr(2'(a), v);
      chk("async_reset_reg", v, 32'd0);
    end
    chk("async_reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    repeat (15) begin
      tick();
      chk("post_reset_irq", {31'd0, irq}, 32'd0);
    end
    rdr(A_COUNT, v);
    chk("post_reset_count", v, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
